// File: rtl/gate_pattern_checker_if.sv
// Bus between the gate pattern checker and the tester/gate side.
// The checker takes the slave view; the stimulus side takes the master view.
interface gate_pattern_checker_if;
  logic       start;
  logic [1:0] mode;
  logic       dut_y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [2:0] vec_idx;
  logic [2:0] fail_vec;
  logic       fail_valid;

  modport master (
    output start, mode, dut_y,
    input  a, b, busy, done, pass, err_count, vec_idx, fail_vec, fail_valid
  );

  modport slave (
    input  start, mode, dut_y,
    output a, b, busy, done, pass, err_count, vec_idx, fail_vec, fail_valid
  );
endinterface

// File: rtl/gate_pattern_checker.sv
// Sweeps a fixed 6-entry {a,b} table into a 2-input gate and counts mismatches.
// Define GATE_CHK_FAILCAP_EN to capture the index of the first failing vector.
module gate_pattern_checker #(
  parameter int unsigned SETTLE = 2  // cycles each vector is held, 1..15
) (
  input logic                   clk,
  input logic                   rst,
  gate_pattern_checker_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] LAST_IDX    = 3'd5;
  localparam logic [2:0] ERR_MAX     = 3'd6;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       y_q, y_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] err_q, err_d;
  logic [2:0] idx_q, idx_d;
  logic       mismatch;

`ifdef GATE_CHK_FAILCAP_EN
  logic [2:0] fail_vec_q, fail_vec_d;
  logic       fail_valid_q, fail_valid_d;
`endif

  function automatic logic [1:0] vec_ab(input logic [2:0] idx);
    logic [1:0] ab;
    case (idx)
      3'd0:    ab = 2'b00;
      3'd1:    ab = 2'b01;
      3'd2:    ab = 2'b10;
      3'd3:    ab = 2'b11;
      3'd4:    ab = 2'b00;
      default: ab = 2'b11;
    endcase
    return ab;
  endfunction

  function automatic logic gate_fn(input logic [1:0] mode, input logic a, input logic b);
    logic y;
    case (mode)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~(a & b);
    endcase
    return y;
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    settle_d = settle_q;
    err_d    = err_q;
    idx_d    = idx_q;
    mismatch = 1'b0;
`ifdef GATE_CHK_FAILCAP_EN
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = DRIVE;
          mode_d     = bus.mode;
          {a_d, b_d} = vec_ab(3'd0);
          idx_d      = 3'd0;
          err_d      = 3'd0;
          settle_d   = 4'd0;
`ifdef GATE_CHK_FAILCAP_EN
          fail_vec_d   = 3'd0;
          fail_valid_d = 1'b0;
`endif
        end
      end

      DRIVE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        y_d     = bus.dut_y;
        state_d = CHECK;
      end

      CHECK: begin
        mismatch = (y_q != gate_fn(mode_q, a_q, b_q));
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + 3'd1;
        end
`ifdef GATE_CHK_FAILCAP_EN
        if (mismatch && !fail_valid_q) begin
          fail_vec_d   = idx_q;
          fail_valid_d = 1'b1;
        end
`endif
        // Last vector stays on the pins while DONE so the result can be inspected.
        if (idx_q < LAST_IDX) begin
          idx_d      = idx_q + 3'd1;
          {a_d, b_d} = vec_ab(idx_q + 3'd1);
          settle_d   = 4'd0;
          state_d    = DRIVE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      y_q      <= 1'b0;
      settle_q <= 4'd0;
      err_q    <= 3'd0;
      idx_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
    end
  end

`ifdef GATE_CHK_FAILCAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vec_q   <= 3'd0;
      fail_valid_q <= 1'b0;
    end else begin
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_valid = fail_valid_q;
`else
  assign bus.fail_vec   = 3'd0;
  assign bus.fail_valid = 1'b0;
`endif

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = (state_q == DRIVE) || (state_q == SAMPLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_q == 3'd0);
  assign bus.err_count = err_q;
  assign bus.vec_idx   = idx_q;

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Scoreboard bench for gate_pattern_checker: expected vectors and sweep results
// are queued when a sweep starts and popped as the checker applies them.
module tb_gate_pattern_checker;

  localparam int SETTLE = 2;
  localparam int PERIOD = SETTLE + 2;

  typedef struct {
    bit         is_result;
    logic [2:0] idx;
    logic [1:0] ab;
    int         offset;
    logic [2:0] err;
    logic [2:0] fvec;
    logic       fvalid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   base_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   gate_kind = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [1:0] cur_ab = 2'b00;
  bit   prev_busy = 1'b0;
  bit   prev_done = 1'b0;
  logic [2:0] prev_idx = 3'd0;

  gate_pattern_checker_if gif ();

  gate_pattern_checker #(.SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test: ideal OR, or output stuck at 1
  assign gif.dut_y = (gate_kind == 0) ? (gif.a | gif.b) : 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] ref_ab(input int k);
    logic [1:0] tbl [6];
    tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b10;
    tbl[3] = 2'b11; tbl[4] = 2'b00; tbl[5] = 2'b11;
    return tbl[k];
  endfunction

  function automatic logic ref_fn(input logic [1:0] m, input logic [1:0] ab);
    case (m)
      2'b00:   return ab[1] & ab[0];
      2'b01:   return ab[1] | ab[0];
      2'b10:   return ab[1] ^ ab[0];
      default: return ~(ab[1] & ab[0]);
    endcase
  endfunction

  function automatic logic model_gate(input int kind, input logic [1:0] ab);
    return (kind == 0) ? (ab[1] | ab[0]) : 1'b1;
  endfunction

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_a"}, gif.a, 0);
    checkOutput({pfx, "_b"}, gif.b, 0);
    checkOutput({pfx, "_busy"}, gif.busy, 0);
    checkOutput({pfx, "_done"}, gif.done, 0);
    checkOutput({pfx, "_pass"}, gif.pass, 0);
    checkOutput({pfx, "_err"}, gif.err_count, 0);
    checkOutput({pfx, "_idx"}, gif.vec_idx, 0);
    checkOutput({pfx, "_fvec"}, gif.fail_vec, 0);
    checkOutput({pfx, "_fvalid"}, gif.fail_valid, 0);
  endtask

  // Queue the expected sweep, then pulse start; returns at the negedge after the start edge
  task automatic applyStimulus(input logic [1:0] m, input int kind);
    exp_t e;
    int   err = 0;
    bit   fvalid = 0;
    int   fvec = 0;
    for (int k = 0; k < 6; k++) begin
      e = '{is_result: 1'b0, idx: 3'(k), ab: ref_ab(k), offset: k * PERIOD,
            err: 3'd0, fvec: 3'd0, fvalid: 1'b0};
      sb_q.push_back(e);
      if (model_gate(kind, ref_ab(k)) != ref_fn(m, ref_ab(k))) begin
        if (!fvalid) begin
          fvalid = 1;
          fvec   = k;
        end
        err++;
      end
    end
`ifdef GATE_CHK_FAILCAP_EN
    e = '{is_result: 1'b1, idx: 3'd5, ab: 2'b11, offset: 6 * PERIOD,
          err: 3'(err), fvec: 3'(fvec), fvalid: fvalid};
`else
    e = '{is_result: 1'b1, idx: 3'd5, ab: 2'b11, offset: 6 * PERIOD,
          err: 3'(err), fvec: 3'd0, fvalid: 1'b0};
`endif
    sb_q.push_back(e);
    @(negedge clk);
    gate_kind = kind;
    gif.mode  = m;
    gif.start = 1'b1;
    @(posedge clk);
    #1 base_cyc = cyc;
    @(negedge clk);
    gif.start = 1'b0;
  endtask

  task automatic waitDone(input bit disturb);
    int n = 0;
    while (!(gif.done && sb_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
      if (disturb) begin
        if (n == 3 || n == 11 || n == 17) begin
          gif.start = 1'b1;
          gif.mode  = ~gif.mode;
        end else begin
          gif.start = 1'b0;
        end
      end
    end
    gif.start = 1'b0;
    checkOutput("sweep_completed", (n < 300), 1);
    if (n >= 300) sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (gif.busy && (!prev_busy || gif.vec_idx != prev_idx)) begin
        if (sb_q.size() == 0 || sb_q[0].is_result) begin
          checkOutput("sb_unexpected_vec", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("vec_idx", gif.vec_idx, mon_e.idx);
          checkOutput("vec_ab", {gif.a, gif.b}, mon_e.ab);
          checkOutput("vec_time", cyc - base_cyc, mon_e.offset);
          cur_ab = mon_e.ab;
        end
      end else if (gif.busy) begin
        checkOutput("hold_ab", {gif.a, gif.b}, cur_ab);
      end
      if (gif.done && !prev_done) begin
        if (sb_q.size() == 0 || !sb_q[0].is_result) begin
          checkOutput("sb_unexpected_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("res_time", cyc - base_cyc, mon_e.offset);
          checkOutput("res_err", gif.err_count, mon_e.err);
          checkOutput("res_pass", gif.pass, (mon_e.err == 0));
          checkOutput("res_busy", gif.busy, 0);
          checkOutput("res_idx", gif.vec_idx, mon_e.idx);
          checkOutput("res_ab", {gif.a, gif.b}, mon_e.ab);
          checkOutput("res_fvec", gif.fail_vec, mon_e.fvec);
          checkOutput("res_fvalid", gif.fail_valid, mon_e.fvalid);
        end
      end
      if (!gif.done) checkOutput("pass_without_done", gif.pass, 0);
    end
    prev_busy = gif.busy;
    prev_done = gif.done;
    prev_idx  = gif.vec_idx;
  end

  initial begin
    int n;
    rst       = 1'b1;
    gif.start = 1'b0;
    gif.mode  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    $display("[TB] OR mode against OR gate");
    applyStimulus(2'b01, 0);
    waitDone(0);

    $display("[TB] AND mode against OR gate, restarted from DONE");
    applyStimulus(2'b00, 0);
    waitDone(0);

    $display("[TB] NAND mode against stuck-at-1");
    applyStimulus(2'b11, 1);
    waitDone(0);

    $display("[TB] XOR mode against stuck-at-1");
    applyStimulus(2'b10, 1);
    waitDone(0);

    $display("[TB] start re-pulsed and mode toggled mid-sweep");
    applyStimulus(2'b01, 0);
    waitDone(1);

    $display("[TB] reset during CHECK of vector 3");
    applyStimulus(2'b01, 0);
    n = 0;
    while (cyc != base_cyc + 4 * PERIOD - 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_idx", gif.vec_idx, 3);
    checkOutput("mid_busy", gif.busy, 1);
    mon_en = 1'b0;
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    checkReset("midrst");
    rst    = 1'b0;
    mon_en = 1'b1;
    applyStimulus(2'b01, 0);
    waitDone(0);

    $display("[TB] start and rst together in IDLE");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    gif.start = 1'b1;
    @(negedge clk);
    checkOutput("rst_start_busy", gif.busy, 0);
    checkOutput("rst_start_done", gif.done, 0);
    checkOutput("rst_start_idx", gif.vec_idx, 0);
    rst       = 1'b0;
    gif.start = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", gif.busy, 0);
    checkOutput("sb_leftover", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_pattern_checker.md
GATE_PATTERN_CHECKER -- requirements
Module: gate_pattern_checker

Interface
REQ-001 Parameter SETTLE, default 2, sets the number of cycles each vector is held before sampling; legal range is 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: requests a sweep; sampled only in IDLE or DONE.
REQ-005 Port mode, input, 2 bits: expected gate function; 00=AND, 01=OR, 10=XOR, 11=NAND.
REQ-006 Port dut_y, input, 1 bit: output of the gate under test.
REQ-007 Port a, output, 1 bit: first gate input driven to the DUT (registered).
REQ-008 Port b, output, 1 bit: second gate input driven to the DUT (registered).
REQ-009 Port busy, output, 1 bit: high in DRIVE, SAMPLE and CHECK.
REQ-010 Port done, output, 1 bit: high while in DONE.
REQ-011 Port pass, output, 1 bit: equals done AND (err_count==0).
REQ-012 Port err_count, output, 3 bits: number of mismatching vectors in the current or last sweep.
REQ-013 Port vec_idx, output, 3 bits: index of the vector currently applied (0..5).
REQ-014 Port fail_vec, output, 3 bits: index of the first failing vector (see Configuration).
REQ-015 Port fail_valid, output, 1 bit: high once a first failure has been captured (see Configuration).

Function
REQ-016 The vector table is fixed, as {a,b}: idx0=00, idx1=01, idx2=10, idx3=11, idx4=00, idx5=11.
REQ-017 The FSM has the states IDLE, DRIVE, SAMPLE, CHECK and DONE.
REQ-018 IDLE/DONE with start=1 at edge N: latch mode, drive {a,b}=vector 0, set vec_idx=0, clear err_count and the settle counter, clear the fail capture, and go to DRIVE.
REQ-019 DRIVE: hold a and b stable and increment the settle counter; on the SETTLE-th DRIVE edge go to SAMPLE.
REQ-020 SAMPLE: register dut_y into an internal y_q and go to CHECK.
REQ-021 CHECK: compare y_q with the expected value f(mode_latched,a,b) and increment err_count on a mismatch.
REQ-022 CHECK continued: if vec_idx<5, load the next vector, increment vec_idx, reset the settle counter and go to DRIVE; otherwise go to DONE.
REQ-023 Timing: vector k is applied from edge N+k*(SETTLE+2), and done rises after edge N+6*(SETTLE+2).
REQ-024 DONE holds a, b, err_count and vec_idx=5 until reset or a new start.
REQ-025 start is ignored while busy=1; mode changes after the latch have no effect on the running sweep.
REQ-026 err_count never wraps (maximum 6); pass is 0 whenever done=0.
REQ-027 start=1 in DONE restarts the sweep with the same timing as from IDLE.

Reset
REQ-028 When rst=1 at an edge, the next state is IDLE, regardless of the current state, including mid-sweep.
REQ-029 Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, fail_vec=0, fail_valid=0.
REQ-030 rst takes priority over start in the same cycle.

Configuration
REQ-031 With macro GATE_CHK_FAILCAP_EN defined: on the first mismatch in a sweep, CHECK sets fail_vec=vec_idx and fail_valid=1.
REQ-032 With GATE_CHK_FAILCAP_EN defined: these values stay sticky until reset or the next start.
REQ-033 With GATE_CHK_FAILCAP_EN undefined: fail_vec and fail_valid are tied to 0, no capture logic is generated, and all other behaviour is identical.

Verification
REQ-034 Scenario 1: SETTLE=2, mode=01, DUT is an ideal OR, start pulsed at edge N -> the a/b sequence is 00,01,10,11,00,11 with each vector held 4 cycles; done=1 and pass=1 after edge N+24; err_count=0.
REQ-035 Scenario 2: mode=00 against an OR DUT -> mismatches at idx1 and idx2; err_count=2, pass=0 and done=1; with the macro defined, fail_vec=1 and fail_valid=1.
REQ-036 Scenario 3: mode=11 with dut_y stuck at 1 -> a mismatch only at idx3 and idx5; err_count=2.
REQ-037 Scenario 4: rst asserted for 1 cycle while in CHECK of idx3 -> the next cycle is IDLE with all outputs at their reset values; a subsequent start gives the full 24-cycle sweep.
REQ-038 Scenario 5: start re-pulsed while busy, and mode toggled mid-sweep -> no restart and no change in expected values; the result matches Scenario 1.
REQ-039 Scenario 6: start and rst both high in IDLE -> the block stays in IDLE with busy=0.
